// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The helpers build the KMP automaton from a compile-time pattern; they are never used at run time.
package seq_det_pkg;

  localparam logic MODE_MOORE = 1'b0;
  localparam logic MODE_MEALY = 1'b1;

  // Widest pattern the helpers can carry in their fixed-width argument.
  localparam int unsigned MAX_N = 64;

  // Bit i of the received order (i=0 is the first bit, held in pattern[n-1]).
  function automatic logic pat_bit(input logic [MAX_N-1:0] pattern,
                                   input int unsigned n, input int unsigned i);
    logic [MAX_N-1:0] t;
    t = pattern >> (n - 1 - i);
    return t[0];
  endfunction

  // Length of the longest proper border of the k-bit prefix.
  function automatic int unsigned fail_len(input logic [MAX_N-1:0] pattern,
                                           input int unsigned n, input int unsigned k);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned l = 1; l < k; l++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < l; i++) begin
        if (pat_bit(pattern, n, i) != pat_bit(pattern, n, k - l + i)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Automaton step from partial-match length e (< n) on bit x.
  function automatic int unsigned next_len(input logic [MAX_N-1:0] pattern,
                                           input int unsigned n, input int unsigned e,
                                           input logic x);
    int unsigned s;
    int unsigned r;
    logic        done;
    s    = e;
    r    = 0;
    done = 1'b0;
    // Each failure link strictly shrinks s, so n+1 iterations always terminate.
    for (int unsigned j = 0; j <= n; j++) begin
      if (!done) begin
        if (pat_bit(pattern, n, s) == x) begin
          r    = s + 1;
          done = 1'b1;
        end else if (s == 0) begin
          r    = 0;
          done = 1'b1;
        end else begin
          s = fail_len(pattern, n, s);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational KMP next-state lookup (state, x, ovl) -> next state, tables built at elaboration.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int unsigned  N       = 6,
  parameter logic [N-1:0] PATTERN = 6'b010110,
  parameter int unsigned  SW      = $clog2(N + 1)
) (
  input  logic [SW-1:0] state_i,
  input  logic          x,
  input  logic          ovl,
  output logic [SW-1:0] next_c
);

  localparam int unsigned      DEPTH   = 2 ** SW;
  localparam logic [MAX_N-1:0] PAT_EXT = MAX_N'(PATTERN);
  localparam logic [SW-1:0]    BORDER  = SW'(fail_len(PAT_EXT, N, N));
  localparam logic [SW-1:0]    FULL    = SW'(N);

  logic [SW-1:0] nxt0 [DEPTH];
  logic [SW-1:0] nxt1 [DEPTH];
  logic [SW-1:0] eff;

  // Tables padded to a power of two so any state code indexes safely.
  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    if (g < N) begin : g_live
      assign nxt0[g] = SW'(next_len(PAT_EXT, N, g, 1'b0));
      assign nxt1[g] = SW'(next_len(PAT_EXT, N, g, 1'b1));
    end else begin : g_dead
      assign nxt0[g] = '0;
      assign nxt1[g] = '0;
    end
  end

  // A completed match restarts from the border (overlap) or from zero.
  always_comb begin
    eff = state_i;
    if (state_i == FULL) eff = ovl ? BORDER : '0;
    next_c = x ? nxt1[eff] : nxt0[eff];
  end

endmodule

// File: rtl/pattern_seq_detector.sv
// Parametrised serial pattern detector: state register, Moore/Mealy decode and saturating match counter.
module pattern_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned  N       = 6,
  parameter logic [N-1:0] PATTERN = 6'b010110,
  parameter int unsigned  CNT_W   = 8,
  localparam int unsigned SW      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             valid,
  input  logic             m,
  input  logic             ovl,
  input  logic             count_clr,
  output logic             z,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [SW-1:0]    FULL    = SW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0]    state_q, state_d;
  logic [SW-1:0]    next_c;
  logic             moore_z_q, moore_z_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit_c;

  seq_det_next_state #(
    .N       (N),
    .PATTERN (PATTERN),
    .SW      (SW)
  ) u_next (
    .state_i (state_q),
    .x       (x),
    .ovl     (ovl),
    .next_c  (next_c)
  );

  // Next-state, Moore decode and counter update; hit is independent of m.
  always_comb begin
    state_d   = state_q;
    moore_z_d = moore_z_q;
    count_d   = count_q;
    hit_c     = valid & (next_c == FULL);
    if (valid) begin
      state_d   = next_c;
      moore_z_d = hit_c;
    end
    if (count_clr) begin
      count_d = hit_c ? CNT_W'(1) : '0;
    end else if (hit_c && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= '0;
      moore_z_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      moore_z_q <= moore_z_d;
      count_q   <= count_d;
    end
  end

  // Mode only selects the decode; the state path never sees m.
  always_comb begin
    z = 1'b0;
    case (m)
      MODE_MOORE: z = moore_z_q;
      MODE_MEALY: z = hit_c;
      default:    z = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Self-checking bench for pattern_seq_detector: vector table plus hand-written corner sequences.
module tb_pattern_seq_detector;

  typedef struct {
    bit         rst;
    logic       x;
    logic       v;
    logic       m;
    logic       o;
    logic       clr;
    logic       z;
    logic [2:0] st;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset, x, valid, m, ovl, count_clr;
  logic       za, zb, zc;
  logic [2:0] sta, stb, stc;
  logic [7:0] cnta, cntc;
  logic [1:0] cntb;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pattern_seq_detector u_a (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .m(m), .ovl(ovl),
    .count_clr(count_clr), .z(za), .state(sta), .match_count(cnta)
  );

  pattern_seq_detector #(.CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .m(m), .ovl(ovl),
    .count_clr(count_clr), .z(zb), .state(stb), .match_count(cntb)
  );

  pattern_seq_detector #(.N(4), .PATTERN(4'b1111)) u_c (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .m(m), .ovl(ovl),
    .count_clr(count_clr), .z(zc), .state(stc), .match_count(cntc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic xi, vi, mi, oi, ci, zi,
                     input logic [2:0] s, input logic [7:0] c);
    vec_t e;
    e.rst = r; e.x = xi; e.v = vi; e.m = mi; e.o = oi; e.clr = ci;
    e.z = zi; e.st = s; e.cnt = c;
    tbl.push_back(e);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after release.
  task automatic do_reset();
    reset = 1'b0; valid = 1'b0; x = 1'b0; count_clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Drive one bit at posedge+1, sample combinational z at negedge, return at next posedge+1.
  task automatic drive(input logic xi, vi, ci, output logic a_o, b_o, c_o);
    x = xi; valid = vi; count_clr = ci;
    #4;
    a_o = za; b_o = zb; c_o = zc;
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, output int pa, pb, pc);
    logic [15:0] t;
    logic a, b, c;
    pa = 0; pb = 0; pc = 0;
    for (int i = 0; i < n; i++) begin
      t = bits >> (n - 1 - i);
      drive(t[0], 1'b1, 1'b0, a, b, c);
      pa += int'(a); pb += int'(b); pc += int'(c);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, b, c;
    int pa, pb, pc, ta, tb_n;

    // Overlap on, Mealy: 01011010110
    add(1,0,1,1,1,0, 0,1,0); add(0,1,1,1,1,0, 0,2,0); add(0,0,1,1,1,0, 0,3,0);
    add(0,1,1,1,1,0, 0,4,0); add(0,1,1,1,1,0, 0,5,0); add(0,0,1,1,1,0, 1,6,1);
    add(0,1,1,1,1,0, 0,2,1); add(0,0,1,1,1,0, 0,3,1); add(0,1,1,1,1,0, 0,4,1);
    add(0,1,1,1,1,0, 0,5,1); add(0,0,1,1,1,0, 1,6,2);
    // Overlap off, Mealy
    add(1,0,1,1,0,0, 0,1,0); add(0,1,1,1,0,0, 0,2,0); add(0,0,1,1,0,0, 0,3,0);
    add(0,1,1,1,0,0, 0,4,0); add(0,1,1,1,0,0, 0,5,0); add(0,0,1,1,0,0, 1,6,1);
    add(0,1,1,1,0,0, 0,0,1); add(0,0,1,1,0,0, 0,1,1); add(0,1,1,1,0,0, 0,2,1);
    add(0,1,1,1,0,0, 0,0,1); add(0,0,1,1,0,0, 0,1,1);
    // Overlap on, Moore: z lags one cycle and holds across valid=0
    add(1,0,1,0,1,0, 0,1,0); add(0,1,1,0,1,0, 0,2,0); add(0,0,1,0,1,0, 0,3,0);
    add(0,1,1,0,1,0, 0,4,0); add(0,1,1,0,1,0, 0,5,0); add(0,0,1,0,1,0, 0,6,1);
    add(0,1,1,0,1,0, 1,2,1); add(0,0,1,0,1,0, 0,3,1); add(0,1,1,0,1,0, 0,4,1);
    add(0,1,1,0,1,0, 0,5,1); add(0,0,1,0,1,0, 0,6,2);
    add(0,1,0,0,1,0, 1,6,2); add(0,0,0,0,1,0, 1,6,2);
    add(0,1,1,0,1,0, 1,2,2); add(0,0,1,0,1,0, 0,3,2);
    // m toggled mid-stream: state path identical to the overlap case
    add(1,0,1,0,1,0, 0,1,0); add(0,1,1,0,1,0, 0,2,0); add(0,0,1,1,1,0, 0,3,0);
    add(0,1,1,1,1,0, 0,4,0); add(0,1,1,0,1,0, 0,5,0); add(0,0,1,1,1,0, 1,6,1);
    add(0,1,1,0,1,0, 1,2,1); add(0,0,1,1,1,0, 0,3,1); add(0,1,1,0,1,0, 0,4,1);
    add(0,1,1,0,1,0, 0,5,1); add(0,0,1,1,1,0, 1,6,2); add(0,0,0,0,1,0, 1,6,2);
    // valid gaps inside 010110, Mealy
    add(1,0,1,1,1,0, 0,1,0); add(0,1,1,1,1,0, 0,2,0); add(0,0,1,1,1,0, 0,3,0);
    add(0,1,0,1,1,0, 0,3,0); add(0,1,1,1,1,0, 0,4,0); add(0,0,0,1,1,0, 0,4,0);
    add(0,1,0,1,1,0, 0,4,0); add(0,1,1,1,1,0, 0,5,0); add(0,0,0,1,1,0, 0,5,0);
    add(0,0,1,1,1,0, 1,6,1);

    reset = 1'b0; x = 1'b0; valid = 1'b0; m = 1'b0; ovl = 1'b1; count_clr = 1'b0;
    #2;
    chk("reset state", 32'(sta), 32'd0);
    chk("reset count", 32'(cnta), 32'd0);
    chk("reset z moore", 32'(za), 32'd0);
    m = 1'b1; valid = 1'b1; #1;
    chk("reset z mealy", 32'(za), 32'd0);
    valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      m = tbl[i].m; ovl = tbl[i].o;
      drive(tbl[i].x, tbl[i].v, tbl[i].clr, a, b, c);
      chk($sformatf("vec%0d z", i), 32'(a), 32'(tbl[i].z));
      chk($sformatf("vec%0d state", i), 32'(sta), 32'(tbl[i].st));
      chk($sformatf("vec%0d count", i), 32'(cnta), 32'(tbl[i].cnt));
    end

    // Asynchronous reset mid-pattern
    do_reset(); m = 1'b1; ovl = 1'b1;
    feed(16'b010110010, 9, pa, pb, pc);
    chk("pre-reset state", 32'(sta), 32'd3);
    chk("pre-reset count", 32'(cnta), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async reset state", 32'(sta), 32'd0);
    chk("async reset count", 32'(cnta), 32'd0);
    chk("async reset z mealy", 32'(za), 32'd0);
    m = 1'b0; #1;
    chk("async reset z moore", 32'(za), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; m = 1'b1;
    feed(16'b010110, 6, pa, pb, pc);
    chk("post-reset pulses", 32'(pa), 32'd1);
    chk("post-reset count", 32'(cnta), 32'd1);

    // Saturating counter and count_clr interaction
    do_reset(); m = 1'b1; ovl = 1'b1;
    feed(16'b010110, 6, ta, tb_n, pc);
    for (int k = 0; k < 4; k++) begin
      feed(16'b10110, 5, pa, pb, pc);
      ta += pa; tb_n += pb;
    end
    chk("five matches pulses", 32'(ta), 32'd5);
    chk("five matches pulses w2", 32'(tb_n), 32'd5);
    chk("count w8 after 5", 32'(cnta), 32'd5);
    chk("count w2 saturated", 32'(cntb), 32'd3);
    chk("state w2 after 5", 32'(stb), 32'd6);
    feed(16'b1011, 4, pa, pb, pc);
    drive(1'b0, 1'b1, 1'b1, a, b, c);
    chk("clr+hit z", 32'(a), 32'd1);
    chk("clr+hit count w8", 32'(cnta), 32'd1);
    chk("clr+hit count w2", 32'(cntb), 32'd1);
    drive(1'b1, 1'b1, 1'b1, a, b, c);
    chk("clr no hit count w8", 32'(cnta), 32'd0);
    chk("clr no hit count w2", 32'(cntb), 32'd0);
    chk("clr no hit state", 32'(sta), 32'd2);

    // Pattern 1111 with overlap: six ones give three matches
    do_reset(); m = 1'b1; ovl = 1'b1;
    feed(16'b111111, 6, pa, pb, pc);
    chk("1111 pulses", 32'(pc), 32'd3);
    chk("1111 count", 32'(cntc), 32'd3);
    chk("1111 state", 32'(stc), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
